// File: rtl/sir_sim_pkg.sv
// ---------------------------------------------------------------------------
// sir_sim_pkg : Q16.16 constants, sequencer state codes, saturating helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sir_sim_pkg;

    localparam logic [31:0] ONE     = 32'd65536;
    localparam logic [31:0] MU      = 32'd6554;
    localparam logic [31:0] ALPHA   = 32'd6553600;
    localparam logic [31:0] BETA    = 32'd3277;
    localparam logic [31:0] P0      = 32'd65536000;
    localparam logic [31:0] P1      = 32'd13107;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    // M1..UPDATE are consecutive so a multiply phase advances by +1.
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOAD   = 4'd1;
    localparam logic [3:0] ST_M1     = 4'd2;
    localparam logic [3:0] ST_M2     = 4'd3;
    localparam logic [3:0] ST_M3     = 4'd4;
    localparam logic [3:0] ST_M4     = 4'd5;
    localparam logic [3:0] ST_M5     = 4'd6;
    localparam logic [3:0] ST_M6     = 4'd7;
    localparam logic [3:0] ST_UPDATE = 4'd8;
    localparam logic [3:0] ST_EMIT   = 4'd9;
    localparam logic [3:0] ST_DONE   = 4'd10;

    typedef struct packed {
        logic        ovf;
        logic [31:0] val;
    } sat32_t;

    function automatic sat32_t sat33(input logic [32:0] x);
        sat32_t res;
        if (x[32] != x[31]) begin
            res = {1'b1, (x[32] ? SAT_MIN : SAT_MAX)};
        end else begin
            res = {1'b0, x[31:0]};
        end
        return res;
    endfunction

    function automatic sat32_t sat_add(input logic [31:0] a, input logic [31:0] b);
        return sat33({a[31], a} + {b[31], b});
    endfunction

    function automatic sat32_t sat_sub(input logic [31:0] a, input logic [31:0] b);
        return sat33({a[31], a} - {b[31], b});
    endfunction

endpackage

`default_nettype wire

// File: rtl/fixmul_q16.sv
// ---------------------------------------------------------------------------
// fixmul_q16 : MUL_LAT-stage signed Q16.16 multiplier with saturation flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fixmul_q16
    import sir_sim_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p,
    output logic        ovf
);

    localparam logic signed [63:0] LIM_HI = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] LIM_LO = -64'sh0000_0000_8000_0000;

    logic signed [63:0] prod;
    logic signed [63:0] shifted;
    logic [32:0]        stage_d;
    logic [32:0]        pipe_q [MUL_LAT];

    always_comb begin
        prod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        shifted = prod >>> 16;
        if (shifted > LIM_HI) begin
            stage_d = {1'b1, SAT_MAX};
        end else if (shifted < LIM_LO) begin
            stage_d = {1'b1, SAT_MIN};
        end else begin
            stage_d = {1'b0, shifted[31:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= stage_d;
            for (int k = 1; k < MUL_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign {ovf, p} = pipe_q[MUL_LAT-1];

endmodule

`default_nettype wire

// File: rtl/sir_step_sequencer.sv
// ---------------------------------------------------------------------------
// sir_step_sequencer : explicit-Euler stepper for the (I, R, P) model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sir_step_sequencer
    import sir_sim_pkg::*;
#(
    parameter int STEP_W   = 16,
    parameter int MUL_LAT  = 2,
    parameter int DT_SHIFT = 11
) (
    input  logic              clk,
    input  logic              go,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [31:0]       i_init,
    input  logic [31:0]       r_init,
    input  logic [31:0]       sin_mag,
    input  logic              sin_sign,
    output logic [31:0]       t_out,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [STEP_W-1:0] step_cnt,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [31:0]       i_out,
    output logic [31:0]       r_out,
    output logic [31:0]       p_out
);

    localparam int          CYC_W = $clog2(MUL_LAT + 1);
    localparam logic [31:0] T_INC = 32'(1 << (16 - DT_SHIFT));

    logic [3:0]        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [STEP_W-1:0] steps_q, steps_d, step_cnt_q, step_cnt_d;
    logic [31:0]       i_q, i_d, r_q, r_d, p_q, p_d, t_q, t_d;
    logic [31:0]       m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, m4_q, m4_d, m5_q, m5_d;
    logic              sign_q, sign_d, ovf_q, ovf_d;

    logic [31:0] mul_a, mul_b, mul_p;
    logic        mul_ovf, opnd_ovf, issue, last, in_mul;
    logic [31:0] di_shift, dr_shift;
    sat32_t      sum_ir, one_adj, d_i, d_r, i_new, r_new;

    fixmul_q16 #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk (clk),
        .rst (go),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    assign sum_ir   = sat_add(i_q, r_q);
    assign one_adj  = sign_q ? sat_add(ONE, m5_q) : sat_sub(ONE, m5_q);
    assign d_i      = sat_sub(p_q, m2_q);
    assign d_r      = sat_sub(m3_q, m4_q);
    assign di_shift = $unsigned($signed(d_i.val) >>> DT_SHIFT);
    assign dr_shift = $unsigned($signed(d_r.val) >>> DT_SHIFT);
    assign i_new    = sat_add(i_q, di_shift);
    assign r_new    = sat_add(r_q, dr_shift);

    assign issue  = (cyc_q == '0);
    assign last   = (cyc_q == CYC_W'(MUL_LAT));
    assign in_mul = (state_q >= ST_M1) && (state_q <= ST_M6);

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        steps_d    = steps_q;
        step_cnt_d = step_cnt_q;
        i_d        = i_q;
        r_d        = r_q;
        p_d        = p_q;
        t_d        = t_q;
        m1_d       = m1_q;
        m2_d       = m2_q;
        m3_d       = m3_q;
        m4_d       = m4_q;
        m5_d       = m5_q;
        sign_d     = sign_q;
        ovf_d      = ovf_q;
        mul_a      = 32'd0;
        mul_b      = 32'd0;
        opnd_ovf   = 1'b0;

        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                i_d        = i_init;
                r_d        = r_init;
                t_d        = 32'd0;
                step_cnt_d = '0;
                ovf_d      = 1'b0;
                steps_d    = num_steps;
                cyc_d      = '0;
                state_d    = (num_steps == '0) ? ST_DONE : ST_M1;
            end
            ST_M1: begin
                mul_a    = sum_ir.val;
                mul_b    = i_q;
                opnd_ovf = sum_ir.ovf;
                if (last) m1_d = mul_p;
            end
            ST_M2: begin
                mul_a = MU;
                mul_b = m1_q;
                if (last) m2_d = mul_p;
            end
            ST_M3: begin
                mul_a = ALPHA;
                mul_b = i_q;
                if (last) m3_d = mul_p;
            end
            ST_M4: begin
                mul_a = BETA;
                mul_b = r_q;
                if (last) m4_d = mul_p;
            end
            ST_M5: begin
                mul_a = P1;
                mul_b = sin_mag;
                if (issue) sign_d = sin_sign;
                if (last)  m5_d   = mul_p;
            end
            ST_M6: begin
                mul_a    = P0;
                mul_b    = one_adj.val;
                opnd_ovf = one_adj.ovf;
                if (last) p_d = mul_p;
            end
            ST_UPDATE: begin
                i_d        = i_new.val;
                r_d        = r_new.val;
                ovf_d      = ovf_q | d_i.ovf | d_r.ovf | i_new.ovf | r_new.ovf;
                t_d        = t_q + T_INC;
                step_cnt_d = step_cnt_q + 1'b1;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (sample_ready) state_d = (step_cnt_q == steps_q) ? ST_DONE : ST_M1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Shared phase timing: operand flags count at issue, product flags at capture.
        if (in_mul) begin
            ovf_d = ovf_q | (issue & opnd_ovf) | (last & mul_ovf);
            if (last) begin
                cyc_d   = '0;
                state_d = state_q + 4'd1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge go) begin
        if (go) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            steps_q    <= '0;
            step_cnt_q <= '0;
            i_q        <= '0;
            r_q        <= '0;
            p_q        <= '0;
            t_q        <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            m3_q       <= '0;
            m4_q       <= '0;
            m5_q       <= '0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            steps_q    <= steps_d;
            step_cnt_q <= step_cnt_d;
            i_q        <= i_d;
            r_q        <= r_d;
            p_q        <= p_d;
            t_q        <= t_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            m3_q       <= m3_d;
            m4_q       <= m4_d;
            m5_q       <= m5_d;
            sign_q     <= sign_d;
            ovf_q      <= ovf_d;
        end
    end

    assign t_out        = t_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign sample_valid = (state_q == ST_EMIT);
    assign ovf          = ovf_q;
    assign step_cnt     = step_cnt_q;
    assign i_out        = i_q;
    assign r_out        = r_q;
    assign p_out        = p_q;

endmodule

`default_nettype wire

// File: tb/tb_sir_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sir_step_sequencer : vector table, stall/reset sequences, random runs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sir_step_sequencer;

    logic        clk = 1'b0;
    logic        go, start, sin_sign, sample_ready;
    logic [15:0] num_steps, step_cnt;
    logic [31:0] i_init, r_init, sin_mag, t_out, i_out, r_out, p_out;
    logic        busy, done, ovf, sample_valid;

    sir_step_sequencer #(.STEP_W(16), .MUL_LAT(2), .DT_SHIFT(11)) dut (
        .clk          (clk),
        .go           (go),
        .start        (start),
        .num_steps    (num_steps),
        .i_init       (i_init),
        .r_init       (r_init),
        .sin_mag      (sin_mag),
        .sin_sign     (sin_sign),
        .t_out        (t_out),
        .busy         (busy),
        .done         (done),
        .ovf          (ovf),
        .step_cnt     (step_cnt),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i_out        (i_out),
        .r_out        (r_out),
        .p_out        (p_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: one Euler step per loop pass ----------------
    localparam longint K_ONE = 65536, K_MU = 6554, K_ALPHA = 6553600;
    localparam longint K_BETA = 3277, K_P0 = 65536000, K_P1 = 13107;

    longint mq_i[$], mq_r[$], mq_p[$];
    bit     m_ovf;

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647)  begin m_ovf = 1'b1; return 64'sd2147483647;  end
        if (v < -64'sd2147483648) begin m_ovf = 1'b1; return -64'sd2147483648; end
        return v;
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        return sat((a * b) >>> 16);
    endfunction

    function automatic longint sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    task automatic model_run(input longint i0, input longint r0, input longint mag,
                             input bit sgn, input int n);
        longint iv, rv, pv, m1, m2, m3, m4, m5;
        mq_i.delete(); mq_r.delete(); mq_p.delete();
        m_ovf = 1'b0;
        iv = i0; rv = r0;
        for (int s = 0; s < n; s++) begin
            m1 = qmul(sat(iv + rv), iv);
            m2 = qmul(K_MU, m1);
            m3 = qmul(K_ALPHA, iv);
            m4 = qmul(K_BETA, rv);
            m5 = qmul(K_P1, mag);
            pv = qmul(K_P0, sgn ? sat(K_ONE + m5) : sat(K_ONE - m5));
            iv = sat(iv + (sat(pv - m2) >>> 11));
            rv = sat(rv + (sat(m3 - m4) >>> 11));
            mq_i.push_back(iv); mq_r.push_back(rv); mq_p.push_back(pv);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic [31:0] got_i[$], got_r[$], got_p[$];
    int          load_cyc, first_valid_cyc;

    task automatic start_run(input logic [31:0] i0, input logic [31:0] r0,
                             input logic [31:0] mag, input logic sgn, input logic [15:0] n);
        @(negedge clk);
        i_init = i0; r_init = r0; sin_mag = mag; sin_sign = sgn; num_steps = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_cyc = cyc;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready held low 10 cycles per sample
    task automatic collect(input int mode, input int stop_after, output bit timed_out);
        bit          held;
        int          wait_cnt;
        logic [31:0] hi, hr, hp;
        got_i.delete(); got_r.delete(); got_p.delete();
        first_valid_cyc = -1;
        held = 1'b0; wait_cnt = 0; timed_out = 1'b1;
        hi = '0; hr = '0; hp = '0;
        for (int k = 0; k < 4000; k++) begin
            if (done) begin timed_out = 1'b0; break; end
            if (sample_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (held) begin
                    check("stall_i_stable", i_out, hi);
                    check("stall_r_stable", r_out, hr);
                    check("stall_p_stable", p_out, hp);
                end else begin
                    held = 1'b1; hi = i_out; hr = r_out; hp = p_out;
                end
                case (mode)
                    0:       sample_ready = 1'b1;
                    1:       sample_ready = 1'($urandom % 2);
                    default: sample_ready = (wait_cnt >= 10);
                endcase
                wait_cnt++;
                if (sample_ready) begin
                    got_i.push_back(i_out); got_r.push_back(r_out); got_p.push_back(p_out);
                    held = 1'b0; wait_cnt = 0;
                    if (got_i.size() == stop_after) begin timed_out = 1'b0; return; end
                end
            end else begin
                sample_ready = (mode == 1) ? 1'($urandom % 2) : 1'b0;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [31:0] i0, r0, mag;
        logic        sgn;
        logic [15:0] n;
        logic [31:0] ei, er, ep, et;
        logic        eovf;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit to;
        int busy_cycles;
        bit saw_valid;

        // single step from I=10; sin effect off, negative-going, positive-going; saturation; clean rerun
        vecs[0] = '{32'h000A0000, 0, 0,     1'b0, 16'd1, 32'd687039,     32'd32000,   32'd65536000, 32'd32, 1'b0};
        vecs[1] = '{32'h000A0000, 0, 65536, 1'b0, 16'd1, 32'd680640,     32'd32000,   32'd52429000, 32'd32, 1'b0};
        vecs[2] = '{32'h000A0000, 0, 65536, 1'b1, 16'd1, 32'd693439,     32'd32000,   32'd78643000, 32'd32, 1'b0};
        vecs[3] = '{32'h7F000000, 0, 0,     1'b0, 16'd1, 32'd2130633568, 32'd1048575, 32'd65536000, 32'd32, 1'b1};
        vecs[4] = vecs[0];

        go = 1'b1; start = 1'b0; sample_ready = 1'b0; num_steps = '0;
        i_init = '0; r_init = '0; sin_mag = '0; sin_sign = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_outputs", {i_out, r_out, p_out}, 0);
        check("reset_misc", {t_out, step_cnt, done, ovf, sample_valid}, 0);
        go = 1'b0;

        // zero-step run: LOAD then DONE, no sample
        start_run(32'h000A0000, 0, 0, 1'b0, 16'd0);
        busy_cycles = 0; saw_valid = 1'b0;
        check("zero_load_done", done, 0);
        for (int k = 0; k < 5; k++) begin
            if (busy) busy_cycles++;
            if (sample_valid) saw_valid = 1'b1;
            if (k == 1) check("zero_done_pulse", done, 1);
            if (k == 2) check("zero_done_clear", done, 0);
            @(negedge clk);
        end
        check("zero_busy_cycles", busy_cycles, 2);
        check("zero_no_valid", saw_valid, 0);

        // vector table
        for (int v = 0; v < 5; v++) begin
            start_run(vecs[v].i0, vecs[v].r0, vecs[v].mag, vecs[v].sgn, vecs[v].n);
            collect(0, 0, to);
            check("vec_completes", to, 0);
            check("vec_samples", got_i.size(), 1);
            if (got_i.size() == 1) begin
                check("vec_i_out", got_i[0], vecs[v].ei);
                check("vec_r_out", got_r[0], vecs[v].er);
                check("vec_p_out", got_p[0], vecs[v].ep);
            end
            check("vec_t_out", t_out, vecs[v].et);
            check("vec_step_cnt", step_cnt, 32'(vecs[v].n));
            check("vec_ovf", ovf, vecs[v].eovf);
            if (v == 0) check("vec_first_valid_latency", first_valid_cyc - load_cyc, 20);
            repeat (3) @(negedge clk);
            check("idle_hold_i", i_out, vecs[v].ei);
            check("idle_not_busy", busy, 0);
        end

        // three steps with ready stalled at every sample
        start_run(32'h000A0000, 0, 0, 1'b0, 16'd3);
        collect(2, 0, to);
        model_run(sx(32'h000A0000), 0, 0, 1'b0, 3);
        check("stall_completes", to, 0);
        check("stall_transfers", got_i.size(), 3);
        for (int k = 0; k < got_i.size() && k < 3; k++) begin
            check("stall_i", got_i[k], 32'(mq_i[k]));
            check("stall_r", got_r[k], 32'(mq_r[k]));
            check("stall_p", got_p[k], 32'(mq_p[k]));
        end
        check("stall_step_cnt", step_cnt, 3);

        // reset during M3 of the second step, then a clean rerun
        start_run(32'h000A0000, 0, 0, 1'b0, 16'd3);
        collect(0, 1, to);
        check("midreset_first_sample", to, 0);
        repeat (7) @(negedge clk);
        go = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_data", {i_out, r_out, p_out}, 0);
        check("midreset_misc", {t_out, step_cnt, done, ovf, sample_valid}, 0);
        @(negedge clk);
        go = 1'b0;
        start_run(vecs[0].i0, vecs[0].r0, vecs[0].mag, vecs[0].sgn, vecs[0].n);
        collect(0, 0, to);
        check("rerun_completes", to, 0);
        check("rerun_samples", got_i.size(), 1);
        if (got_i.size() == 1) begin
            check("rerun_i", got_i[0], vecs[0].ei);
            check("rerun_r", got_r[0], vecs[0].er);
            check("rerun_p", got_p[0], vecs[0].ep);
        end
        check("rerun_t", t_out, vecs[0].et);

        // randomized runs against the model
        for (int run = 0; run < 8; run++) begin
            logic [31:0] ri, rr, rm;
            logic        rs;
            int          rn;
            ri = $urandom_range(0, 50 * 65536);
            rr = $urandom_range(0, 20 * 65536);
            rm = $urandom_range(0, 65536);
            rs = 1'($urandom % 2);
            rn = $urandom_range(1, 4);
            start_run(ri, rr, rm, rs, 16'(rn));
            collect(1, 0, to);
            model_run(sx(ri), sx(rr), sx(rm), rs, rn);
            check("rand_completes", to, 0);
            check("rand_transfers", got_i.size(), rn);
            for (int k = 0; k < got_i.size() && k < rn; k++) begin
                check("rand_i", got_i[k], 32'(mq_i[k]));
                check("rand_r", got_r[k], 32'(mq_r[k]));
                check("rand_p", got_p[k], 32'(mq_p[k]));
            end
            check("rand_step_cnt", step_cnt, rn);
            check("rand_t", t_out, 32 * rn);
            check("rand_ovf", ovf, m_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
